// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC/IR owner with imem req/ack handshake
//
// Purpose:
//   Owns the program counter and instruction register of the multicycle RV32
//   core. A fetch_req from the control unit starts one fetch. The request is
//   held on imem_req until imem_ack. The completion is reported with a
//   one-cycle fetch_done pulse. A misaligned PC at request time, or MAX_WAIT
//   request cycles without an ack, parks the unit in a sticky fault state.
//   Only reset leaves the fault state.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   fetch_req        request one fetch (honoured only in IDLE)
//   pc_next_sel      0: pc <= pc+4, 1: pc <= branch_target (sampled at ack edge)
//   branch_target    jump/branch target from the datapath
//   imem_req         memory request, high for the whole REQ state
//   imem_addr        fetch address, equal to pc
//   imem_ack         memory response valid
//   imem_rdata       instruction word, valid with imem_ack
//   pc, pc_plus4     current PC (registered) and its combinational successor
//   ir               instruction register
//   fetch_done       one-cycle pulse once pc/ir hold the new values
//   busy             high while in REQ or DONE
//   fetch_fault      sticky fault flag

module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            pc_next_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ir,
  output logic            fetch_done,
  output logic            busy,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [8:0]      MAX_WAIT_W = 9'(MAX_WAIT);

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [7:0]      r_wait_cnt;
  logic [8:0]      w_wait_inc;
  logic            w_timeout;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Count including the current REQ cycle: on the last of MAX_WAIT unacked
  // cycles this reaches MAX_WAIT, so imem_req is high exactly MAX_WAIT cycles.
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
  assign w_timeout  = (w_wait_inc >= MAX_WAIT_W);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_req) begin
          // Misaligned PC faults before any memory request is issued.
          w_state_next = (r_pc[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_REQ: begin
        // An ack on the timeout cycle takes priority over the fault.
        if (imem_ack) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (fetch_req) begin
            r_wait_cnt <= 8'd0;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
            r_pc <= pc_next_sel ? branch_target : w_pc_plus4;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // All control outputs decode directly from the state register.
  assign imem_req    = (r_state == S_REQ);
  assign fetch_done  = (r_state == S_DONE);
  assign busy        = (r_state == S_REQ) || (r_state == S_DONE);
  assign fetch_fault = (r_state == S_FAULT);

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign ir        = r_ir;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle RV32 core, directly upstream of the control unit. It owns the program counter and instruction register and runs a req/ack handshake with instruction memory, which may take a variable number of cycles to answer. It signals the control unit with a one-cycle completion pulse. A wait-cycle timeout or a misaligned PC raises a sticky fault.

## Interface
- XLEN, 32: datapath width; fixed at 32 for RV32.
- RESET_PC, 32'h0000_0000: PC value after reset.
- MAX_WAIT, 15: number of REQ cycles without imem_ack that triggers a fault; legal range 1..255.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- fetch_req  input  1  from the control unit FETCH state; request one instruction fetch.
- pc_next_sel  input  1  0: next PC = pc+4; 1: next PC = branch_target.
- branch_target  input  32  jump/branch target from the datapath.
- imem_req  output  1  memory request; held high until ack.
- imem_addr  output  32  equals pc.
- imem_ack  input  1  memory response valid.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- pc  output  32  current program counter (registered).
- pc_plus4  output  32  combinational pc+4, modulo 2^32.
- ir  output  32  instruction register.
- fetch_done  output  1  one-cycle pulse after ir and pc are updated.
- busy  output  1  high in REQ and DONE.
- fetch_fault  output  1  sticky fault flag; cleared only by reset.

## Operation
- States: IDLE, REQ, DONE, FAULT. A 2-bit encoded state register.
- IDLE:
  - fetch_req=1 and pc[1:0]==0 -> REQ; wait counter cleared.
  - fetch_req=1 and pc[1:0]!=0 -> FAULT; no memory request is issued.
  - imem_ack is ignored.
- REQ:
  - imem_req=1; imem_addr=pc, held stable.
  - imem_ack=1 at the edge:
    - ir <= imem_rdata.
    - pc <= (pc_next_sel ? branch_target : pc_plus4); pc_next_sel and branch_target are sampled at that same edge.
    - Next state DONE.
  - imem_ack=0: wait counter increments. When the counter reaches MAX_WAIT -> FAULT, with pc and ir unchanged.
- DONE: fetch_done=1 for exactly one cycle, then -> IDLE.
- FAULT: fetch_fault=1, imem_req=0, busy=0. The unit ignores all inputs and holds until reset.
- fetch_req while busy is ignored. It is not queued.
- Arithmetic:
  - pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - The wait counter is 8 bits and saturates; it never wraps.
- A misaligned branch_target is accepted into pc. The fault is raised at the next fetch_req.

## Timing
- Reset values:
  - pc = RESET_PC; ir = 32'h0000_0013 (NOP).
  - imem_req=0, fetch_done=0, busy=0, fetch_fault=0; state IDLE; wait counter 0.
- Reset asserted mid-fetch: imem_req drops immediately (asynchronous). A late imem_ack after reset is ignored because the state is IDLE.
- Latency: fetch_req sampled at edge N.
  - imem_req is high in cycle N+1.
  - With ack in the same cycle, pc and ir update at edge N+2; fetch_done is high in cycle N+2.
  - Each wait cycle adds one cycle.
- Minimum fetch_req-to-fetch_done spacing is 2 cycles. A new fetch_req may be presented in the cycle after fetch_done (IDLE).
- Timeout: imem_req is high for exactly MAX_WAIT cycles. fetch_fault rises in the following cycle.
- An imem_ack coinciding with the timeout edge wins: the fetch completes and no fault is raised.
- Outputs pc, ir, imem_req, fetch_done, busy, and fetch_fault are registered or state-decoded only. imem_addr follows pc.

## Test plan
- Reset, then fetch_req with imem_ack returned on the first REQ cycle and imem_rdata=32'h0020_8133:
  - imem_addr=0.
  - ir=32'h0020_8133 and pc=4 at edge N+2.
  - fetch_done high for exactly one cycle.
- pc_next_sel=1 with branch_target=32'h0000_0100 at the ack edge -> pc=32'h100. The next fetch has imem_addr=32'h100.
- Wrap-around:
  - RESET_PC=32'hFFFF_FFFC, fetch with ack -> pc=0 and pc_plus4=4.
  - A later fetch from branch_target=32'h102 -> fetch_fault=1 with no imem_req pulse.
- Memory wait of 3 cycles, with fetch_req re-asserted during REQ:
  - imem_req high for 4 cycles and imem_addr stable throughout.
  - One completion only; the extra request is ignored.
- MAX_WAIT=15 with no ack:
  - fetch_fault=1 after 15 REQ cycles; pc and ir unchanged.
  - fetch_req is then ignored until reset.
  - Repeat with ack arriving on the 15th cycle -> normal completion, no fault.
- Reset asserted in the second REQ cycle, then imem_ack=1 one cycle later:
  - imem_req=0 immediately; pc=RESET_PC; ir=NOP.
  - No fetch_done pulse.
